// File: rtl/sram_access_ctrl.sv
// Two-requester arbiter for a single-port byte-addressable SRAM macro.
// Each request is arbitrated, legality-checked, given one SRAM cycle and answered with a held response.
module sram_access_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter bit RR_EN  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                m0_req_valid,
    output logic                m0_req_ready,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic                m0_rsp_valid,
    input  logic                m0_rsp_ready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_rsp_err,
    input  logic                m1_req_valid,
    output logic                m1_req_ready,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic                m1_rsp_valid,
    input  logic                m1_rsp_ready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_rsp_err,
    output logic [DATA_W/8-1:0] sram_w_en,
    output logic [ADDR_W-1:0]   sram_address,
    output logic [DATA_W-1:0]   sram_write_data,
    input  logic [DATA_W-1:0]   sram_read_data
);
    localparam int STRB_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'((1 << ADDR_W) - 4);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last_grant;
    logic                r_port;
    logic                r_err;
    logic [STRB_W-1:0]   r_wstrb;
    logic [ADDR_W-1:0]   r_sram_addr;
    logic [DATA_W-1:0]   r_sram_wdata;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_any;
    logic                w_grant1;
    logic [ADDR_W-1:0]   w_addr;
    logic [STRB_W-1:0]   w_wstrb;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_legal;
    logic                w_rsp_hs;

    // Round-robin only breaks ties: m1 wins a tie when m0 was granted last.
    assign w_any    = m0_req_valid | m1_req_valid;
    assign w_grant1 = m1_req_valid & (~m0_req_valid | (RR_EN & ~r_last_grant));
    assign w_addr   = w_grant1 ? m1_addr  : m0_addr;
    assign w_wstrb  = w_grant1 ? m1_wstrb : m0_wstrb;
    assign w_wdata  = w_grant1 ? m1_wdata : m0_wdata;
    assign w_legal  = ((w_wstrb == 4'b0000) || (w_wstrb == 4'b0001) ||
                       (w_wstrb == 4'b0011) || (w_wstrb == 4'b1111)) &&
                      (w_addr <= ADDR_LAST);
    assign w_rsp_hs = r_port ? m1_rsp_ready : m0_rsp_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        w_state_nxt  = r_state;
        m0_req_ready = 1'b0;
        m1_req_ready = 1'b0;
        m0_rsp_valid = 1'b0;
        m1_rsp_valid = 1'b0;
        sram_w_en    = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    m0_req_ready = ~w_grant1;
                    m1_req_ready = w_grant1;
                    w_state_nxt  = w_legal ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                sram_w_en   = r_wstrb;
                w_state_nxt = RESP;
            end
            RESP: begin
                m0_rsp_valid = ~r_port;
                m1_rsp_valid = r_port;
                if (w_rsp_hs) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_port       <= 1'b0;
            r_err        <= 1'b0;
            r_wstrb      <= '0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_rdata      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_any) begin
                r_port       <= w_grant1;
                r_last_grant <= w_grant1;
                r_wstrb      <= w_wstrb;
                r_err        <= ~w_legal;
                // Illegal requests never reach the SRAM pins, which keep their last values.
                if (w_legal) begin
                    r_sram_addr  <= w_addr;
                    r_sram_wdata <= w_wdata;
                end else begin
                    r_rdata <= '0;
                end
            end
            if (r_state == ACCESS) r_rdata <= sram_read_data;
        end
    end

    assign sram_address    = r_sram_addr;
    assign sram_write_data = r_sram_wdata;
    assign m0_rdata        = r_rdata;
    assign m1_rdata        = r_rdata;
    assign m0_rsp_err      = m0_rsp_valid & r_err;
    assign m1_rsp_err      = m1_rsp_valid & r_err;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl: a byte-lane SRAM model behind a round-robin instance,
// plus a fixed-priority instance sharing the request inputs for the arbitration comparison.
module tb_sram_access_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req_valid, m0_req_ready, m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
    logic [15:0] m0_addr;
    logic [3:0]  m0_wstrb;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m1_req_valid, m1_req_ready, m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
    logic [15:0] m1_addr;
    logic [3:0]  m1_wstrb;
    logic [31:0] m1_wdata, m1_rdata;
    logic [3:0]  sram_w_en;
    logic [15:0] sram_address;
    logic [31:0] sram_write_data, sram_read_data;

    logic        fp_m0_req_ready, fp_m0_rsp_valid, fp_m0_rsp_err;
    logic        fp_m1_req_ready, fp_m1_rsp_valid, fp_m1_rsp_err;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_write_data;
    logic [3:0]  fp_w_en;
    logic [15:0] fp_address;
    logic [31:0] fp_read_data = 32'h0;

    logic [7:0]  mem [0:65535];
    int          n_pass = 0;
    int          n_total = 0;
    int          wen_cycles = 0;

    always #5 clk = ~clk;

    sram_access_ctrl #(.ADDR_W(16), .DATA_W(32), .RR_EN(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
        .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata), .m0_rsp_valid(m0_rsp_valid),
        .m0_rsp_ready(m0_rsp_ready), .m0_rdata(m0_rdata), .m0_rsp_err(m0_rsp_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
        .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata), .m1_rsp_valid(m1_rsp_valid),
        .m1_rsp_ready(m1_rsp_ready), .m1_rdata(m1_rdata), .m1_rsp_err(m1_rsp_err),
        .sram_w_en(sram_w_en), .sram_address(sram_address),
        .sram_write_data(sram_write_data), .sram_read_data(sram_read_data)
    );

    sram_access_ctrl #(.ADDR_W(16), .DATA_W(32), .RR_EN(1'b0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_req_valid(m0_req_valid), .m0_req_ready(fp_m0_req_ready), .m0_addr(m0_addr),
        .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata), .m0_rsp_valid(fp_m0_rsp_valid),
        .m0_rsp_ready(m0_rsp_ready), .m0_rdata(fp_m0_rdata), .m0_rsp_err(fp_m0_rsp_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(fp_m1_req_ready), .m1_addr(m1_addr),
        .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata), .m1_rsp_valid(fp_m1_rsp_valid),
        .m1_rsp_ready(m1_rsp_ready), .m1_rdata(fp_m1_rdata), .m1_rsp_err(fp_m1_rsp_err),
        .sram_w_en(fp_w_en), .sram_address(fp_address),
        .sram_write_data(fp_write_data), .sram_read_data(fp_read_data)
    );

    // Little-endian byte-lane SRAM with combinational read.
    assign sram_read_data = {mem[sram_address + 16'd3], mem[sram_address + 16'd2],
                             mem[sram_address + 16'd1], mem[sram_address]};

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (sram_w_en[i]) mem[sram_address + 16'(i)] <= sram_write_data[8*i +: 8];
    end

    always @(negedge clk) if (sram_w_en != 4'b0000) wen_cycles++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        m0_req_valid = 1'b0; m0_addr = '0; m0_wstrb = '0; m0_wdata = '0;
        m1_req_valid = 1'b0; m1_addr = '0; m1_wstrb = '0; m1_wdata = '0;
        m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic xfer(input bit p, input logic [15:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] rd, output logic e,
                        output int lat);
        int n;
        @(posedge clk); #1;
        if (!p) begin m0_req_valid = 1'b1; m0_addr = a; m0_wstrb = s; m0_wdata = d; end
        else    begin m1_req_valid = 1'b1; m1_addr = a; m1_wstrb = s; m1_wdata = d; end
        n = 0;
        @(negedge clk);
        while (!(p ? m1_req_ready : m0_req_ready) && n < 20) begin @(negedge clk); n++; end
        check("req_ready", p ? m1_req_ready : m0_req_ready, 1);
        @(posedge clk); #1;
        m0_req_valid = 1'b0; m1_req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!(p ? m1_rsp_valid : m0_rsp_valid) && lat < 20) begin @(negedge clk); lat++; end
        rd = p ? m1_rdata : m0_rdata;
        e  = p ? m1_rsp_err : m0_rsp_err;
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat, w0, n;
        int          gr_rr[$];
        int          gr_fp[$];

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        reset_dut();

        @(negedge clk);
        check("rst_m0_req_ready", m0_req_ready, 0);
        check("rst_m1_req_ready", m1_req_ready, 0);
        check("rst_m0_rsp_valid", m0_rsp_valid, 0);
        check("rst_m1_rsp_valid", m1_rsp_valid, 0);
        check("rst_rsp_err", {m0_rsp_err, m1_rsp_err}, 0);
        check("rst_w_en", sram_w_en, 0);
        check("rst_address", sram_address, 0);
        check("rst_write_data", sram_write_data, 0);
        check("rst_rdata", m0_rdata | m1_rdata, 0);

        w0 = wen_cycles;
        xfer(1, 16'h0010, 4'b1111, 32'hDEADBEEF, rd, e, lat);
        check("wr_word_latency", lat, 2);
        check("wr_word_prewrite", rd, 32'h0);
        check("wr_word_err", e, 0);
        check("wr_word_wen_cycles", wen_cycles - w0, 1);

        xfer(1, 16'h0010, 4'b0000, 32'h0, rd, e, lat);
        check("rd_word_latency", lat, 2);
        check("rd_word_data", rd, 32'hDEADBEEF);
        check("rd_word_err", e, 0);

        xfer(1, 16'h0010, 4'b0001, 32'h000000AA, rd, e, lat);
        check("wr_byte_prewrite", rd, 32'hDEADBEEF);
        xfer(1, 16'h0010, 4'b0000, 32'h0, rd, e, lat);
        check("rd_after_byte", rd, 32'hDEADBEAA);

        xfer(1, 16'h0010, 4'b0011, 32'h00001234, rd, e, lat);
        xfer(1, 16'h0010, 4'b0000, 32'h0, rd, e, lat);
        check("rd_after_half", rd, 32'hDEAD1234);

        xfer(0, 16'hFFFC, 4'b1111, 32'hCAFEF00D, rd, e, lat);
        check("wr_top_err", e, 0);
        xfer(0, 16'hFFFC, 4'b0000, 32'h0, rd, e, lat);
        check("rd_top_data", rd, 32'hCAFEF00D);
        check("rd_top_err", e, 0);

        w0 = wen_cycles;
        xfer(1, 16'h0010, 4'b0101, 32'hFFFFFFFF, rd, e, lat);
        check("bad_strb_err", e, 1);
        check("bad_strb_rdata", rd, 0);
        check("bad_strb_latency", lat, 1);
        xfer(0, 16'hFFFD, 4'b0000, 32'h0, rd, e, lat);
        check("bad_addr_err", e, 1);
        check("bad_addr_rdata", rd, 0);
        check("bad_no_wen", wen_cycles - w0, 0);
        check("bad_addr_held", sram_address, 16'hFFFC);
        xfer(1, 16'h0010, 4'b0000, 32'h0, rd, e, lat);
        check("bad_mem_unchanged", rd, 32'hDEAD1234);

        // Reset while the write sits in ACCESS: nothing may reach the SRAM.
        @(posedge clk); #1;
        m0_req_valid = 1'b1; m0_addr = 16'h0040; m0_wstrb = 4'b1111; m0_wdata = 32'h55555555;
        @(negedge clk);
        check("midrst_accept", m0_req_ready, 1);
        @(posedge clk); #1;
        m0_req_valid = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_w_en", sram_w_en, 0);
        check("midrst_rsp_valid", m0_rsp_valid, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_no_rsp", m0_rsp_valid | m1_rsp_valid, 0);
        xfer(0, 16'h0040, 4'b0000, 32'h0, rd, e, lat);
        check("midrst_not_written", rd, 32'h0);
        check("midrst_idle_latency", lat, 2);

        // Both ports requesting continuously.
        reset_dut();
        @(posedge clk); #1;
        m0_req_valid = 1'b1; m0_addr = 16'h0100; m0_wstrb = 4'b0000;
        m1_req_valid = 1'b1; m1_addr = 16'h0200; m1_wstrb = 4'b0000;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (m0_req_ready) gr_rr.push_back(0);
            if (m1_req_ready) gr_rr.push_back(1);
            if (fp_m0_req_ready) gr_fp.push_back(0);
            if (fp_m1_req_ready) gr_fp.push_back(1);
        end
        check("rr_grant_count", gr_rr.size(), 6);
        check("fp_grant_count", gr_fp.size(), 6);
        for (int k = 0; k < 6 && k < gr_rr.size(); k++) check("rr_grant_order", gr_rr[k], k % 2);
        for (int k = 0; k < 6 && k < gr_fp.size(); k++) check("fp_grant_m0", gr_fp[k], 0);

        // m0 stalls its response while m1 waits.
        reset_dut();
        m0_rsp_ready = 1'b0;
        @(posedge clk); #1;
        m0_req_valid = 1'b1; m0_addr = 16'h0010; m0_wstrb = 4'b0000;
        @(negedge clk);
        check("stall_m0_accept", m0_req_ready, 1);
        @(posedge clk); #1;
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b1; m1_addr = 16'h0010; m1_wstrb = 4'b0000;
        @(negedge clk);
        check("stall_access_m1_ready", m1_req_ready, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_m0_rsp_valid", m0_rsp_valid, 1);
            check("stall_m0_rdata", m0_rdata, 32'hDEAD1234);
            check("stall_m1_ready", m1_req_ready, 0);
        end
        @(posedge clk); #1 m0_rsp_ready = 1'b1;
        @(negedge clk);
        check("hs_cycle_m1_ready", m1_req_ready, 0);
        @(negedge clk);
        check("post_hs_m0_rsp_valid", m0_rsp_valid, 0);
        check("post_hs_m1_ready", m1_req_ready, 1);
        @(posedge clk); #1 m1_req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!m1_rsp_valid && n < 20) begin @(negedge clk); n++; end
        check("m1_after_stall_valid", m1_rsp_valid, 1);
        check("m1_after_stall_rdata", m1_rdata, 32'hDEAD1234);
        @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
